// File: rtl/dds_pkg.sv
// dds_pkg -- shared definitions for the DDS configuration path.
//   DDS_SIG_WIDTH    : default width of theta/delta/amplitude words.
//   THETAS/DELTAS/AMPLS : bank codes, matching the DDS core address decode.
//   ldr_state_e      : states of the configuration loader.
//   state_bank()     : bank code a loading state expects.
//   next_bank_state(): state that follows a completed bank.
package dds_pkg;

    localparam int DDS_SIG_WIDTH = 16;

    localparam logic [1:0] THETAS = 2'd0;
    localparam logic [1:0] DELTAS = 2'd1;
    localparam logic [1:0] AMPLS  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_THETA,
        ST_LD_DELTA,
        ST_LD_AMPL,
        ST_RUN
    } ldr_state_e;

    function automatic logic [1:0] state_bank(input ldr_state_e s);
        case (s)
            ST_LD_DELTA: return DELTAS;
            ST_LD_AMPL:  return AMPLS;
            default:     return THETAS;
        endcase
    endfunction

    function automatic ldr_state_e next_bank_state(input ldr_state_e s);
        case (s)
            ST_LD_THETA: return ST_LD_DELTA;
            ST_LD_DELTA: return ST_LD_AMPL;
            default:     return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/dds_cfg_loader.sv
// dds_cfg_loader -- sequences theta, delta and amplitude words into the DDS
// shift-register FIFOs in strict bank order, then releases the DDS into run.
//   clk, i_rst          : clock, synchronous active-high reset
//   i_load_req          : pulse, start (or restart) a load sequence
//   i_stop              : pulse, leave RUN for IDLE (ignored elsewhere)
//   i_clr_err           : clear sticky o_err
//   s_valid/s_ready     : config word handshake
//   s_sel, s_data       : bank tag and config word
//   o_dds_we            : DDS FIFO write strobe, one cycle after a good beat
//   o_dds_addrs         : target bank of the write (held while we=0)
//   o_dds_fifo_data     : written word (held while we=0)
//   o_dds_start         : DDS run enable, never coincident with o_dds_we
//   o_busy              : load in progress (including the final write)
//   o_err               : sticky bank-order error
module dds_cfg_loader
    import dds_pkg::*;
#(
    parameter int SIG_WIDTH = DDS_SIG_WIDTH,
    parameter int N_CH      = 8
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_load_req,
    input  logic                 i_stop,
    input  logic                 i_clr_err,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [1:0]           s_sel,
    input  logic [SIG_WIDTH-1:0] s_data,
    output logic                 o_dds_we,
    output logic [1:0]           o_dds_addrs,
    output logic [SIG_WIDTH-1:0] o_dds_fifo_data,
    output logic                 o_dds_start,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int              CNT_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CH - 1);

    ldr_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [1:0]           addrs_q, addrs_d;
    logic [SIG_WIDTH-1:0] data_q, data_d;
    logic                 start_q, start_d;
    logic                 err_q, err_d;

    logic in_load;
    logic accept;
    logic good_beat;
    logic bad_beat;

    assign in_load   = (state_q == ST_LD_THETA) || (state_q == ST_LD_DELTA) ||
                       (state_q == ST_LD_AMPL);
    assign accept    = s_valid && in_load;
    assign good_beat = accept && (s_sel == state_bank(state_q));
    assign bad_beat  = accept && !good_beat;

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_load_req) begin
                    state_d = ST_LD_THETA;
                    cnt_d   = '0;
                end
            end
            ST_LD_THETA, ST_LD_DELTA, ST_LD_AMPL: begin
                if (good_beat) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = next_bank_state(state_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A restart overrides bank progress, but the beat's write
                // (computed below) still goes out.
                if (i_load_req) begin
                    state_d = ST_LD_THETA;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (i_load_req) begin
                    state_d = ST_LD_THETA;
                    cnt_d   = '0;
                end else if (i_stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        we_d    = good_beat;
        addrs_d = good_beat ? s_sel  : addrs_q;
        data_d  = good_beat ? s_data : data_q;

        // Start only when RUN is both current and next: this delays the rising
        // edge past the final AMPLS write and drops it immediately on exit.
        start_d = (state_q == ST_RUN) && (state_d == ST_RUN);

        // Set has priority over clear.
        if (bad_beat)
            err_d = 1'b1;
        else if (i_clr_err)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            // NOTE: the held address/data registers are reset too, because the
            // outputs they drive must read zero straight out of reset.
            addrs_q <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addrs_q <= addrs_d;
            data_q  <= data_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    assign s_ready         = in_load;
    // The final write lands one cycle after leaving LD_AMPL, so busy covers it.
    assign o_busy          = in_load || we_q;
    assign o_dds_we        = we_q;
    assign o_dds_addrs     = addrs_q;
    assign o_dds_fifo_data = data_q;
    assign o_dds_start     = start_q;
    assign o_err           = err_q;

endmodule
